// File: rtl/accum_display_ctrl.sv
// accum_display_ctrl: debounced-button accumulator with sticky overflow and a 4-digit multiplexed hex display.
module accum_display_ctrl #(
    parameter int DATA_W      = 8,
    parameter int ACC_W       = 16,
    parameter int DEB_CYC     = 4,
    parameter int REFRESH_DIV = 4
) (
    input  logic              MCLK,
    input  logic              reset,
    input  logic [DATA_W-1:0] sw,
    input  logic [3:0]        btn,
    output logic [7:0]        Led,
    output logic [6:0]        seg,
    output logic [3:0]        an,
    output logic              dp,
    output logic              ovf
);
    localparam int CW = $clog2(DEB_CYC + 1);
    localparam int RW = $clog2(REFRESH_DIV + 1);
    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic [3:0]        s1, s2, lvl, lvl_d, pulse;
    logic [CW-1:0]     cnt [4];
    logic [ACC_W-1:0]  acc;
    logic [DATA_W-1:0] opd;
    logic [ACC_W:0]    sum, diff;
    logic [15:0]       acc16;
    logic [RW-1:0]     rcnt;
    logic [1:0]        dig;

    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            s1    <= '0;
            s2    <= '0;
            lvl   <= '0;
            lvl_d <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            lvl_d <= lvl;
            // any sample matching the current level restarts the stability count
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == lvl[i]) cnt[i] <= '0;
                else if (cnt[i] == CW'(DEB_CYC - 1)) begin
                    lvl[i] <= s2[i];
                    cnt[i] <= '0;
                end else cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    assign pulse = lvl & ~lvl_d;
    assign sum   = {1'b0, acc} + (ACC_W+1)'(opd);
    assign diff  = {1'b0, acc} - (ACC_W+1)'(opd);

    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            acc <= '0;
            opd <= '0;
            ovf <= 1'b0;
        end else if (pulse[0]) begin
            acc <= '0;
            opd <= '0;
            ovf <= 1'b0;
        end else if (pulse[1]) opd <= sw;
        else if (pulse[2]) begin
            acc <= sum[ACC_W-1:0];
            ovf <= ovf | sum[ACC_W];
        end else if (pulse[3]) begin
            acc <= diff[ACC_W-1:0];
            ovf <= ovf | diff[ACC_W];
        end
    end

    assign acc16 = 16'(acc);
    assign Led   = acc16[7:0];
    assign dp    = ~ovf;

    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            rcnt <= '0;
            dig  <= '0;
            an   <= 4'b1110;
            seg  <= 7'b1000000;
        end else begin
            rcnt <= (rcnt == RW'(REFRESH_DIV - 1)) ? '0 : rcnt + 1'b1;
            dig  <= (rcnt == RW'(REFRESH_DIV - 1)) ? dig + 1'b1 : dig;
            an   <= ~(4'b0001 << dig);
            seg  <= HEX[acc16[{dig, 2'b00} +: 4]];
        end
    end
endmodule

// File: tb/tb_accum_display_ctrl.sv
// tb_accum_display_ctrl: directed and random stimulus checked every cycle against a behavioural model.
module tb_accum_display_ctrl;
    localparam int DEB = 4;
    localparam int RD  = 4;
    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic       MCLK = 1'b0, reset = 1'b1;
    logic [7:0] sw = '0;
    logic [3:0] btn = '0;
    logic [7:0] Led;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp, ovf;

    accum_display_ctrl #(.DATA_W(8), .ACC_W(16), .DEB_CYC(DEB), .REFRESH_DIV(RD)) dut (
        .MCLK(MCLK), .reset(reset), .sw(sw), .btn(btn),
        .Led(Led), .seg(seg), .an(an), .dp(dp), .ovf(ovf)
    );

    always #5 MCLK = ~MCLK;

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // model: levels flip when the last DEB synchronized samples all disagree
    int         n, md, ms;
    logic [15:0] m_acc;
    logic [7:0]  m_opd;
    bit          m_ovf, mvalid, all_diff;
    bit          m_lvl [4], m_lvld [4], p [4];
    bit          hist [4][DEB+1];
    logic [3:0]  e_an;
    logic [6:0]  e_seg;

    always @(posedge MCLK) begin
        if (reset) begin
            n = 0; m_acc = 0; m_opd = 0; m_ovf = 0;
            for (int i = 0; i < 4; i++) begin
                m_lvl[i] = 0; m_lvld[i] = 0;
                for (int k = 0; k <= DEB; k++) hist[i][k] = 0;
            end
            e_an = 4'b1110; e_seg = HEX[0];
        end else begin
            md = (n / RD) % 4;
            e_an = ~(4'b0001 << md);
            e_seg = HEX[(m_acc >> (4 * md)) & 16'hF];
            n++;
            for (int i = 0; i < 4; i++) p[i] = m_lvl[i] && !m_lvld[i];
            if (p[0]) begin m_acc = 0; m_opd = 0; m_ovf = 0; end
            else if (p[1]) m_opd = sw;
            else if (p[2]) begin
                ms = int'(m_acc) + int'(m_opd);
                if (ms > 65535) m_ovf = 1;
                m_acc = ms[15:0];
            end else if (p[3]) begin
                if (int'(m_acc) < int'(m_opd)) m_ovf = 1;
                m_acc = m_acc - {8'b0, m_opd};
            end
            for (int i = 0; i < 4; i++) begin
                m_lvld[i] = m_lvl[i];
                all_diff = 1;
                for (int k = 1; k <= DEB; k++) if (hist[i][k] == m_lvl[i]) all_diff = 0;
                if (all_diff) m_lvl[i] = !m_lvl[i];
                for (int k = DEB; k >= 1; k--) hist[i][k] = hist[i][k-1];
                hist[i][0] = btn[i];
            end
        end
        mvalid = 1;
    end

    initial forever begin
        @(negedge MCLK);
        if (mvalid) begin
            chk("led", Led, m_acc[7:0]);
            chk("ovf", ovf, m_ovf);
            chk("dp", dp, !m_ovf);
            chk("an", an, e_an);
            chk("seg", seg, e_seg);
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge MCLK);
    endtask

    task automatic press(input int b, input int hold = 8, input int gap = 10);
        btn[b] = 1'b1;
        cyc(hold);
        btn[b] = 1'b0;
        cyc(gap);
    endtask

    logic [6:0] exp_seg;

    initial begin
        cyc(1);
        chk("rst_led", Led, 0);
        chk("rst_an", an, 4'b1110);
        chk("rst_seg", seg, 7'b1000000);
        chk("rst_dp", dp, 1);
        cyc(2);
        #2 reset = 1'b0;
        cyc(2);
        sw = 5; press(1); press(2); press(2);
        chk("load_add2_led", Led, 8'h0A);
        chk("load_add2_ovf", ovf, 0);
        press(0); sw = 2; press(1); press(2); sw = 5; press(1); press(3);
        chk("sub_borrow_led", Led, 8'hFD);
        chk("sub_borrow_ovf", ovf, 1);
        chk("model_acc_fffd", m_acc, 16'hFFFD);
        press(0); sw = 2; press(1); press(3); sw = 3; press(1); press(2);
        chk("carry_led", Led, 8'h01);
        chk("carry_ovf", ovf, 1);
        chk("carry_dp", dp, 0);
        press(2);
        chk("sticky_ovf", ovf, 1);
        chk("sticky_led", Led, 8'h04);
        press(0);
        chk("clear_led", Led, 0);
        chk("clear_ovf", ovf, 0);
        chk("clear_dp", dp, 1);
        sw = 9; press(1); sw = 3;
        btn[1] = 1'b1; btn[2] = 1'b1;
        cyc(8);
        btn = '0;
        cyc(10);
        chk("load_beats_add", Led, 0);
        press(2);
        chk("loaded_operand_add", Led, 3);
        for (int i = 0; i < 10; i++) begin
            btn[2] = ~btn[2];
            cyc(2);
        end
        btn[2] = 1'b0;
        cyc(10);
        chk("glitch_no_add", Led, 3);
        btn[2] = 1'b1;
        cyc(DEB + 2);
        chk("latency_before", Led, 3);
        cyc(1);
        chk("latency_at", Led, 6);
        cyc(10 - (DEB + 3));
        btn[2] = 1'b0;
        cyc(10);
        chk("hold_once", Led, 6);
        press(0); sw = 8'hFF; press(1);
        repeat (18) press(2);
        sw = 8'h46; press(1); press(2);
        chk("scan_led", Led, 8'h34);
        chk("model_acc_1234", m_acc, 16'h1234);
        repeat (20) begin
            cyc(1);
            exp_seg = an == 4'b1110 ? 7'h19 : an == 4'b1101 ? 7'h30 :
                      an == 4'b1011 ? 7'h24 : an == 4'b0111 ? 7'h79 : 7'h7F;
            chk("scan_seg", seg, exp_seg);
        end
        btn[2] = 1'b1;
        cyc(3);
        #2 reset = 1'b1;
        #1;
        chk("async_led", Led, 0);
        chk("async_an", an, 4'b1110);
        chk("async_seg", seg, 7'b1000000);
        chk("async_dp", dp, 1);
        chk("async_ovf", ovf, 0);
        cyc(2);
        #2 reset = 1'b0;
        cyc(12);
        btn[2] = 1'b0;
        cyc(10);
        sw = 7; press(1); press(2);
        chk("after_reset_add", Led, 7);
        repeat (1500) begin
            if ($urandom_range(0, 5) == 0) btn[$urandom_range(0, 3)] ^= 1'b1;
            sw = 8'($urandom);
            cyc(1);
        end
        btn = '0;
        cyc(12);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/accum_display_ctrl.md
ACCUM_DISPLAY_CTRL -- requirements
Module: accum_display_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand width taken from sw.
REQ-002 SHALL have parameter ACC_W, default 16, accumulator width, legal range DATA_W..16.
REQ-003 SHALL have parameter DEB_CYC, default 4, consecutive stable cycles needed to accept a button level.
REQ-004 SHALL have parameter REFRESH_DIV, default 4, clocks per display digit, minimum 1.
REQ-005 SHALL have port MCLK  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port sw  input  DATA_W  operand value.
REQ-008 SHALL have port btn  input  4  raw buttons: [0] clear, [1] load, [2] add, [3] subtract.
REQ-009 SHALL have port Led  output  8  accumulator bits [7:0].
REQ-010 SHALL have port seg  output  7  active-low hex segments {g,f,e,d,c,b,a}.
REQ-011 SHALL have port an  output  4  active-low digit enables; an[0] is the least significant digit.
REQ-012 SHALL have port dp  output  1  active-low decimal point; low means sticky overflow is set.
REQ-013 SHALL have port ovf  output  1  sticky overflow/borrow flag, active-high.

Function
REQ-014 SHALL pass each btn bit through a 2-flop synchronizer.
REQ-015 SHALL give each synchronized bit its own debounce counter: debounced level takes the new value only after DEB_CYC consecutive cycles differing from the current level; any glitch restarts the count.
REQ-016 SHALL produce a one-cycle command pulse on each debounced 0->1 transition; release produces no pulse.
REQ-017 SHALL apply the command on the clock edge that ends the pulse cycle, so a clean press is first visible on acc/Led exactly DEB_CYC+3 rising edges after btn is first sampled high.
REQ-018 Load pulse SHALL capture sw into the operand register; acc is unchanged.
REQ-019 Add pulse SHALL set acc <= (acc + zero-extended operand) mod 2^ACC_W; a carry out SHALL set ovf.
REQ-020 Subtract pulse SHALL set acc <= (acc - zero-extended operand) mod 2^ACC_W; a borrow SHALL set ovf.
REQ-021 Clear pulse SHALL set acc, operand and ovf to 0.
REQ-022 Pulses arriving in the same cycle SHALL resolve as clear > load > add > subtract; only the highest-priority command executes, and lower ones are dropped, not queued.
REQ-023 ovf SHALL be sticky: once set, only a clear command or reset clears it.
REQ-024 Holding a button SHALL execute its command exactly once.
REQ-025 The display SHALL scan four digits in order 0,1,2,3,0,... with each digit active for REFRESH_DIV cycles; exactly one an bit is low at a time.
REQ-026 Digit k SHALL show hex nibble acc[4k+3:4k]; nibbles above ACC_W SHALL read 0.
REQ-027 seg SHALL use the standard hex encoding (0=7'b1000000, 1=7'b1111001, ... F=7'b0001110), registered in the same cycle as its an.
REQ-028 dp SHALL equal ~ovf on every digit.

Reset
REQ-029 reset high SHALL immediately, without waiting for a clock, force acc=0, operand=0, ovf=0, debounced levels=0, debounce counters=0, synchronizers=0, digit index=0 and refresh counter=0.
REQ-030 During reset, outputs SHALL be Led=0, an=4'b1110, seg=7'b1000000 and dp=1.
REQ-031 A command pending mid-debounce when reset asserts SHALL be discarded; a button still held at reset release SHALL be treated as a new press.

Verification
REQ-032 Reset, sw=5, press load, then press add twice -> acc=10, Led=0x0A, ovf=0.
REQ-033 ACC_W=16, acc=0xFFFE, operand=3, press add -> acc=0x0001, ovf=1, dp=0; a following add leaves ovf=1; clear -> acc=0, ovf=0.
REQ-034 acc=2, operand=5, press subtract -> acc=0xFFFD, ovf=1.
REQ-035 btn[2] toggled every 2 cycles for 20 cycles with DEB_CYC=4 -> no add; a clean 10-cycle press -> exactly one add, visible after DEB_CYC+3 edges.
REQ-036 btn[1] and btn[2] raised in the same cycle -> load only, acc unchanged.
REQ-037 acc=0x1234, REFRESH_DIV=4 -> an cycles 1110,1101,1011,0111 with 4 cycles each; seg shows 4,3,2,1 in that order.
